// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, valid/ack handshake, overrun and framing status
module uart_rx #(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic       i_rx_ack,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_overrun,
  output logic       o_frame_err,
  output logic       o_busy
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF = TW'((CLKS_PER_BIT - 1) / 2);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, tick;
  logic [TW-1:0] timer, timer_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, byte_n;
  logic valid_n, ovr_n, ferr_n;
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      timer <= '0;
      idx <= '0;
      shift <= '0;
      o_rx_byte <= '0;
      o_rx_valid <= 1'b0;
      o_overrun <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
      state <= state_n;
      timer <= timer_n;
      idx <= idx_n;
      shift <= shift_n;
      o_rx_byte <= byte_n;
      o_rx_valid <= valid_n;
      o_overrun <= ovr_n;
      o_frame_err <= ferr_n;
    end
  end
  always_comb begin
    tick = timer == LAST;
    state_n = state;
    timer_n = timer + 1'b1;
    idx_n = idx;
    shift_n = shift;
    byte_n = o_rx_byte;
    valid_n = o_rx_valid & ~i_rx_ack;
    ovr_n = o_overrun & ~i_rx_ack;
    ferr_n = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        state_n = rx_s ? IDLE : START;
      end
      START: if (timer == HALF) begin
        timer_n = '0;
        idx_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        timer_n = '0;
        shift_n[idx] = rx_s;
        idx_n = idx + 3'd1;
        state_n = (idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (tick) begin
        timer_n = '0;
        state_n = rx_s ? IDLE : BREAK;
        ferr_n = ~rx_s;
        if (rx_s && valid_n) ovr_n = 1'b1;
        else if (rx_s) begin
          byte_n = shift;
          valid_n = 1'b1;
          ovr_n = 1'b0;
        end
      end
      BREAK: begin
        timer_n = '0;
        state_n = rx_s ? IDLE : BREAK;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level timing model
module tb_uart_rx;
  localparam int N = 16;
  localparam int HALF = (N - 1) / 2;
  localparam int N2 = 2604;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, ack = 1'b0, rx2 = 1'b1, ack2 = 1'b0;
  logic [7:0] rx_byte, rx_byte2;
  logic rx_valid, overrun, frame_err, busy, rx_valid2, overrun2, frame_err2, busy2;
  int cyc = 0, n_chk = 0, n_fail = 0, fe_cnt = 0;
  logic [7:0] m_byte = 8'h00, ev_data = 8'h00;
  logic m_valid = 1'b0, m_ovr = 1'b0;
  int ev_cycle = 0, ev_kind = 0, busy_from = 0, busy_to = 0;
  bit fe2_seen = 1'b0;
  always #5 clk = ~clk;
  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx), .i_rx_ack(ack),
    .o_rx_byte(rx_byte), .o_rx_valid(rx_valid), .o_overrun(overrun),
    .o_frame_err(frame_err), .o_busy(busy)
  );
  uart_rx #(.CLKS_PER_BIT(N2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx2), .i_rx_ack(ack2),
    .o_rx_byte(rx_byte2), .o_rx_valid(rx_valid2), .o_overrun(overrun2),
    .o_frame_err(frame_err2), .o_busy(busy2)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rst) begin
      m_byte = 8'h00;
      m_valid = 1'b0;
      m_ovr = 1'b0;
      ev_kind = 0;
      busy_to = 0;
    end else begin
      if (ack) begin
        m_valid = 1'b0;
        m_ovr = 1'b0;
      end
      if (ev_kind == 1 && cyc == ev_cycle) begin
        if (m_valid) m_ovr = 1'b1;
        else begin
          m_byte = ev_data;
          m_valid = 1'b1;
        end
      end
    end
    if (frame_err) fe_cnt++;
    if (frame_err2) fe2_seen = 1'b1;
    chk("rx_byte", rx_byte, m_byte);
    chk("rx_valid", rx_valid, m_valid);
    chk("overrun", overrun, m_ovr);
    chk("frame_err", frame_err, 32'(ev_kind == 2 && cyc == ev_cycle));
    chk("busy", busy, 32'(cyc >= busy_from && cyc < busy_to));
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask
  task automatic pulse_ack();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int low_hold);
    int s, d, m, e;
    s = cyc;
    d = s + 3;
    m = d + HALF + 1;
    e = m + 9 * N;
    busy_from = d;
    busy_to = stop_ok ? e : 1 << 30;
    ev_cycle = e;
    ev_kind = stop_ok ? 1 : 2;
    ev_data = b;
    rx = 1'b0;
    step(N);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(N);
    end
    if (stop_ok) begin
      rx = 1'b1;
      step(N);
    end else begin
      rx = 1'b0;
      step(low_hold);
      rx = 1'b1;
      busy_to = cyc + 3;
      step(N);
    end
  endtask
  task automatic glitch(input int len);
    busy_from = cyc + 3;
    busy_to = cyc + 3 + HALF + 1;
    rx = 1'b0;
    step(len);
    rx = 1'b1;
    step(2 * N);
  endtask
  task automatic send2(input logic [7:0] b, input int p);
    rx2 = 1'b0;
    step(p);
    for (int i = 0; i < 8; i++) begin
      rx2 = b[i];
      step(p);
    end
    rx2 = 1'b1;
    step(p);
  endtask
  task automatic check2(input string name, input logic [7:0] b);
    int k;
    k = 0;
    while (!rx_valid2 && k < 4 * N2) begin
      step(1);
      k++;
    end
    chk({name, "_valid"}, rx_valid2, 1);
    chk({name, "_byte"}, rx_byte2, b);
    chk({name, "_ferr"}, fe2_seen, 0);
    chk({name, "_ovr"}, overrun2, 0);
    ack2 = 1'b1;
    step(1);
    ack2 = 1'b0;
    step(1);
    chk({name, "_acked"}, rx_valid2, 0);
  endtask
  initial begin
    int s, fe0;
    logic [7:0] b;
    bit ok;
    step(3);
    rst = 1'b0;
    chk("reset_byte", rx_byte, 8'h00);
    chk("reset_valid", rx_valid, 0);
    chk("reset_busy", busy, 0);
    step(5);
    s = cyc;
    fork
      send_frame(8'hA5, 1'b1, 0);
      begin
        wait_until(s + 154);
        chk("a5_not_yet", rx_valid, 0);
        step(1);
        chk("a5_valid", rx_valid, 1);
        chk("a5_byte", rx_byte, 8'hA5);
      end
    join
    chk("a5_busy_after", busy, 0);
    chk("a5_ovr", overrun, 0);
    pulse_ack();
    step(1);
    chk("a5_acked", rx_valid, 0);
    fe0 = fe_cnt;
    glitch(4);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_ferr", fe_cnt, fe0);
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 40);
    chk("3c_ferr_once", fe_cnt, fe0 + 1);
    chk("3c_valid", rx_valid, 0);
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    step(2);
    chk("b2b_byte", rx_byte, 8'h11);
    chk("b2b_ovr", overrun, 1);
    pulse_ack();
    step(1);
    chk("b2b_ack_valid", rx_valid, 0);
    chk("b2b_ack_ovr", overrun, 0);
    send_frame(8'h33, 1'b1, 0);
    step(1);
    chk("33_byte", rx_byte, 8'h33);
    s = cyc;
    fork
      send_frame(8'hFF, 1'b1, 0);
      begin
        wait_until(s + 3 + HALF + 1 + 4 * N + 8);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_valid", rx_valid, 0);
        chk("rst_byte", rx_byte, 8'h00);
        chk("rst_busy", busy, 0);
      end
    join
    send_frame(8'h00, 1'b1, 0);
    step(1);
    chk("after_rst_valid", rx_valid, 1);
    chk("after_rst_byte", rx_byte, 8'h00);
    pulse_ack();
    for (int i = 0; i < 12; i++) begin
      step(int'($urandom_range(0, 20)));
      if ($urandom_range(0, 1) == 1) pulse_ack();
      b = 8'($urandom);
      ok = $urandom_range(0, 4) != 0;
      send_frame(b, ok, N + int'($urandom_range(0, 30)));
    end
    pulse_ack();
    step(4);
    send2(8'h55, 2656);
    check2("slow55", 8'h55);
    send2(8'h55, 2552);
    check2("fast55", 8'h55);
    chk("busy2_idle", busy2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart to the board's bit-timed GPIO UART transmit path.
- Samples the asynchronous serial pin at mid-bit using a clock-cycle bit timer.
- Presents each received byte with a valid/ack handshake, plus overrun and framing status.
- Sits between the board RX pin and user logic, for example a seven-segment or LED display path.

Parameters:
- CLKS_PER_BIT, 2604, i_clk cycles per serial bit (50 MHz / 19200 baud); legal range >= 4.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_rx  input  1  asynchronous serial line; idle high.
- i_rx_ack  input  1  consumer acknowledge; clears o_rx_valid and o_overrun.
- o_rx_byte  output  8  last accepted byte, LSB = first data bit received.
- o_rx_valid  output  1  high while o_rx_byte holds an unacknowledged byte.
- o_overrun  output  1  sticky; a byte completed while o_rx_valid was high.
- o_frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- o_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: o_rx_byte=0x00, o_rx_valid=0, o_overrun=0, o_frame_err=0, o_busy=0, state=IDLE, bit timer=0, bit index=0.
- Synchronizer: 2-flop, reset to 1; all decisions use the synchronized value rx_s, which lags i_rx by 2 cycles.
- Bit timer: counts 0..N-1, then wraps to 0 and fires the sample event. Width is clog2(CLKS_PER_BIT).
- IDLE:
  - rx_s==0 -> START with timer=0.
- START:
  - At timer==(CLKS_PER_BIT-1)/2 (integer division), sample rx_s.
  - rx_s==0 -> DATA, timer=0, index=0.
  - rx_s==1 -> treat as a glitch, return to IDLE; no outputs change.
- DATA:
  - Every CLKS_PER_BIT cycles, shift rx_s into shift[index] (LSB first).
  - After index 7 -> STOP, timer=0.
- STOP:
  - After CLKS_PER_BIT cycles, sample rx_s.
  - rx_s==1 and o_rx_valid==0: o_rx_byte<=shift and o_rx_valid<=1 on the next edge; -> IDLE.
  - rx_s==1 and o_rx_valid==1: discard shift, keep o_rx_byte, set o_overrun<=1; -> IDLE.
  - rx_s==0: o_frame_err pulses for exactly 1 cycle and the byte is discarded, with valid and overrun unchanged; -> BREAK.
- BREAK:
  - Wait until rx_s==1, then -> IDLE. This prevents a false start during a held-low line.
- Handshake:
  - i_rx_ack high on any cycle clears o_rx_valid and o_overrun on the next edge.
  - If ack and a new-byte acceptance fall in the same cycle, acceptance wins: o_rx_valid=1 with the new byte, o_overrun=0.
  - Ack while o_rx_valid==0 has no effect.
- Latency: o_rx_valid rises 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles after the i_rx falling edge of the start bit (±1 cycle of synchronizer phase).
- Back-to-back frames: IDLE is re-entered half a bit before the stop bit ends, so a start bit immediately following the stop bit is captured.
- i_rst mid-frame: on the next edge, all state and outputs return to reset values and the partial byte is lost. After reset, the line must be seen high and then low before a new frame starts (the synchronizer resets to 1).
- o_busy is registered from state: 1 in START, DATA, STOP and BREAK.

Test Plan (CLKS_PER_BIT=16 unless noted):
- Send 0xA5, 8N1, line idle high, no ack -> o_rx_byte=0xA5 and o_rx_valid=1 at cycle 2+7+144+1=154 (±1) after the start edge. o_frame_err and o_overrun stay 0; o_busy low after STOP.
- Hold i_rx low for 4 cycles, then high -> no valid and no frame_err; o_busy high about 7 cycles, then 0.
- Send 0x3C with the stop bit driven 0, held low 40 cycles -> o_frame_err is a 1-cycle pulse; o_rx_valid stays 0; o_busy stays 1 until the line returns high.
- Send 0x11 then 0x22 back-to-back without ack -> o_rx_byte=0x11, o_overrun=1. Pulse i_rx_ack -> valid=0, overrun=0. Send 0x33 -> o_rx_byte=0x33.
- Assert i_rst for 1 cycle during DATA bit 4 of 0xFF -> all outputs reset next cycle. A subsequent 0x00 frame is received correctly as 0x00.
- CLKS_PER_BIT=2604: send 0x55 at a 19200-baud model with ±2% bit-period skew -> 0x55 received, no frame_err.
